// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the branch resolver slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: branch opcode constants, prediction queue entry struct,
//           resolver state enum, fall-through PC helper.
package br_pkg;

    localparam logic [5:0] OPC_BEQ = 6'b000100;
    localparam logic [5:0] OPC_BNE = 6'b000101;

    // One in-flight prediction, stored at fetch time and consumed in order at resolve.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic [31:0] target;
        logic        taken;
    } br_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } br_state_e;

    // Sequential PC after a not-taken branch; wraps modulo 2^32.
    function automatic logic [31:0] fallthrough_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch/execute/predictor-facing signal bundle of the branch resolver.
// Latency: n/a (wires only).
// Backpressure: pred_valid/pred_ready handshake on the push side; res_valid has no ready.
// Modports: master = fetch/execute side (drives pred_* and res_*),
//           slave  = resolver side (drives pred_ready, modify_*, true_taken, redirect_*).
interface branch_resolver_if;

    logic        pred_valid;
    logic        pred_ready;
    logic [31:0] pred_pc;
    logic [31:0] pred_instruction;
    logic [31:0] pred_target;
    logic        pred_taken;

    logic        res_valid;
    logic        res_taken;

    logic [31:0] modify_pc;
    logic [31:0] modify_instruction;
    logic        true_taken;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output pred_valid, pred_pc, pred_instruction, pred_target, pred_taken,
        output res_valid, res_taken,
        input  pred_ready, modify_pc, modify_instruction, true_taken,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  pred_valid, pred_pc, pred_instruction, pred_target, pred_taken,
        input  res_valid, res_taken,
        output pred_ready, modify_pc, modify_instruction, true_taken,
        output redirect_valid, redirect_pc
    );

endinterface

// File: rtl/branch_resolver_queue.sv
// br_queue: synchronous FIFO of in-flight predictions with push/pop/clear.
// Latency: push visible at head the cycle after it is written; head is read combinationally.
// Backpressure: push ignored when full, pop ignored when empty; clear wins over both.
// Ports: clk, rst_n, push/push_dat, pop, clear, head_dat, full, empty.
module br_queue
    import br_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  br_entry_t push_dat,
    input  logic      pop,
    input  logic      clear,
    output br_entry_t head_dat,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    br_entry_t        mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    // One bit wider than the pointers so DEPTH entries (full) differs from 0 (empty).
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign wr_en    = push && !full && !clear;
    assign rd_en    = pop && !empty && !clear;
    assign head_dat = mem[rd_ptr];

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && !rd_en) begin
                count <= count + (AW+1)'(1);
            end else if (rd_en && !wr_en) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: queues fetch predictions, resolves them in order, redirects and flushes on mispredict.
// Latency: resolve outputs and redirect pulse are registered, valid one cycle after res_valid.
// Backpressure: pred_ready low when the queue is full or during the FLUSH window.
// Ports: clk, rst_n, br (branch_resolver_if.slave), flush_o, underflow_err;
//        with BR_RESOLVER_STATS_EN defined also resolved_cnt and mispredict_cnt.
module branch_resolver
    import br_pkg::*;
#(
    parameter int DEPTH        = 4,  // power of two, 2..16
    parameter int FLUSH_CYCLES = 2   // at least 1
) (
    input  logic                clk,
    input  logic                rst_n,
    branch_resolver_if.slave    br,
    output logic                flush_o,
    output logic                underflow_err
`ifdef BR_RESOLVER_STATS_EN
    ,
    output logic [31:0]         resolved_cnt,
    output logic [31:0]         mispredict_cnt
`endif
);

    localparam int FCW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    br_state_e       state_q;
    logic [FCW-1:0]  flush_cnt_q;
    // Low during and for the first edge after reset so pred_ready reads 0 in reset.
    logic            alive_q;

    br_entry_t       head;
    br_entry_t       push_entry;
    logic            q_full;
    logic            q_empty;

    logic            in_idle;
    logic            do_push;
    logic            do_pop;
    logic            mispredict;
    logic            res_on_empty;

    logic [31:0]     modify_pc_q;
    logic [31:0]     modify_instruction_q;
    logic            true_taken_q;
    logic            redirect_valid_q;
    logic [31:0]     redirect_pc_q;
    logic            underflow_q;

    assign in_idle      = (state_q == IDLE);
    // Fullness is the registered queue state, so a same-cycle pop never frees a slot early.
    assign br.pred_ready = alive_q && in_idle && !q_full;
    assign do_push      = br.pred_valid && br.pred_ready;
    assign do_pop       = br.res_valid && in_idle && !q_empty;
    assign mispredict   = do_pop && (br.res_taken != head.taken);
    assign res_on_empty = br.res_valid && in_idle && q_empty;

    assign push_entry = '{pc:          br.pred_pc,
                          instruction: br.pred_instruction,
                          target:      br.pred_target,
                          taken:       br.pred_taken};

    // A mispredict clears the queue, which also drops any same-cycle push.
    br_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (do_push && !mispredict),
        .push_dat (push_entry),
        .pop      (do_pop),
        .clear    (mispredict),
        .head_dat (head),
        .full     (q_full),
        .empty    (q_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
        end
    end

    // Control FSM: FLUSH lasts exactly FLUSH_CYCLES cycles after the mispredict edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
            flush_o     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mispredict) begin
                        state_q     <= FLUSH;
                        flush_cnt_q <= FCW'(FLUSH_CYCLES);
                        flush_o     <= 1'b1;
                    end
                end
                FLUSH: begin
                    flush_cnt_q <= flush_cnt_q - FCW'(1);
                    if (flush_cnt_q == FCW'(1)) begin
                        state_q <= IDLE;
                        flush_o <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    flush_o <= 1'b0;
                end
            endcase
        end
    end

    // Resolve-side outputs; values hold until the next pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modify_pc_q          <= '0;
            modify_instruction_q <= '0;
            true_taken_q         <= 1'b0;
            redirect_valid_q     <= 1'b0;
            redirect_pc_q        <= '0;
            underflow_q          <= 1'b0;
        end else begin
            redirect_valid_q <= mispredict;
            if (do_pop) begin
                modify_pc_q          <= head.pc;
                modify_instruction_q <= head.instruction;
                true_taken_q         <= br.res_taken;
            end
            if (mispredict) begin
                redirect_pc_q <= br.res_taken ? head.target : fallthrough_pc(head.pc);
            end
            if (res_on_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign br.modify_pc          = modify_pc_q;
    assign br.modify_instruction = modify_instruction_q;
    assign br.true_taken         = true_taken_q;
    assign br.redirect_valid     = redirect_valid_q;
    assign br.redirect_pc        = redirect_pc_q;
    assign underflow_err         = underflow_q;

`ifdef BR_RESOLVER_STATS_EN
    // Saturating event counters; they stop at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resolved_cnt   <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (do_pop && (resolved_cnt != '1)) begin
                resolved_cnt <= resolved_cnt + 32'd1;
            end
            if (mispredict && (mispredict_cnt != '1)) begin
                mispredict_cnt <= mispredict_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Testbench for branch_resolver: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model.
// Stats checks are compiled in when BR_RESOLVER_STATS_EN is defined.
module tb_branch_resolver;
    import br_pkg::*;

    localparam int DEPTH        = 4;
    localparam int FLUSH_CYCLES = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush_o;
    logic underflow_err;
`ifdef BR_RESOLVER_STATS_EN
    logic [31:0] resolved_cnt;
    logic [31:0] mispredict_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolver_if bif ();

    branch_resolver #(
        .DEPTH        (DEPTH),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .br            (bif),
        .flush_o       (flush_o),
        .underflow_err (underflow_err)
`ifdef BR_RESOLVER_STATS_EN
        ,
        .resolved_cnt   (resolved_cnt),
        .mispredict_cnt (mispredict_cnt)
`endif
    );

    // Behavioural model state
    br_entry_t   m_q[$];
    int          m_flush_left;
    bit          m_alive;
    logic [31:0] m_mod_pc;
    logic [31:0] m_mod_instr;
    bit          m_true;
    bit          m_redir_v;
    logic [31:0] m_redir_pc;
    bit          m_uf;
    longint      m_res_cnt;
    longint      m_mis_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_flush_left = 0;
        m_alive      = 0;
        m_mod_pc     = '0;
        m_mod_instr  = '0;
        m_true       = 0;
        m_redir_v    = 0;
        m_redir_pc   = '0;
        m_uf         = 0;
        m_res_cnt    = 0;
        m_mis_cnt    = 0;
    endtask

    task automatic check_outputs();
        check("modify_pc",      bif.modify_pc,          m_mod_pc);
        check("modify_instr",   bif.modify_instruction, m_mod_instr);
        check("true_taken",     32'(bif.true_taken),    32'(m_true));
        check("redirect_valid", 32'(bif.redirect_valid), 32'(m_redir_v));
        check("redirect_pc",    bif.redirect_pc,        m_redir_pc);
        check("flush_o",        32'(flush_o),           32'(m_flush_left > 0));
        check("underflow_err",  32'(underflow_err),     32'(m_uf));
        check("count",          32'(dut.u_queue.count), 32'(m_q.size()));
`ifdef BR_RESOLVER_STATS_EN
        check("resolved_cnt",   resolved_cnt,   32'(m_res_cnt));
        check("mispredict_cnt", mispredict_cnt, 32'(m_mis_cnt));
`endif
    endtask

    // Called at a negedge: apply inputs, check ready, advance model, clock, check outputs.
    task automatic step(input bit pv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] tgt, input bit pt, input bit rv, input bit rt);
        bit        exp_rdy;
        bit        do_push;
        bit        mis;
        br_entry_t h;
        bif.pred_valid       = pv;
        bif.pred_pc          = pc;
        bif.pred_instruction = ins;
        bif.pred_target      = tgt;
        bif.pred_taken       = pt;
        bif.res_valid        = rv;
        bif.res_taken        = rt;
        exp_rdy = m_alive && (m_flush_left == 0) && (m_q.size() < DEPTH);
        #1;
        check("pred_ready", 32'(bif.pred_ready), 32'(exp_rdy));
        do_push   = pv && exp_rdy;
        mis       = 0;
        m_redir_v = 0;
        if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (rv) begin
            if (m_q.size() == 0) begin
                m_uf = 1;
            end else begin
                h = m_q.pop_front();
                m_mod_pc    = h.pc;
                m_mod_instr = h.instruction;
                m_true      = rt;
                if (m_res_cnt < 64'hFFFF_FFFF) m_res_cnt++;
                if (rt != h.taken) begin
                    mis          = 1;
                    m_redir_v    = 1;
                    m_redir_pc   = rt ? h.target : h.pc + 32'd4;
                    m_flush_left = FLUSH_CYCLES;
                    m_q.delete();
                    if (m_mis_cnt < 64'hFFFF_FFFF) m_mis_cnt++;
                end
            end
        end
        if (do_push && !mis) m_q.push_back('{pc: pc, instruction: ins, target: tgt, taken: pt});
        m_alive = 1;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        step(0, '0, '0, '0, 0, 0, 0);
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] tgt, input bit pt);
        step(1, pc, {OPC_BEQ, 26'(pc)}, tgt, pt, 0, 0);
    endtask

    task automatic resolve(input bit rt);
        step(0, '0, '0, '0, 0, 1, rt);
    endtask

    // Asserts reset at a negedge, checks all outputs are zero, then releases.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_pred_ready", 32'(bif.pred_ready), 32'd0);
        check("rst_modify_pc",  bif.modify_pc, 32'd0);
        check("rst_modify_ins", bif.modify_instruction, 32'd0);
        check("rst_true_taken", 32'(bif.true_taken), 32'd0);
        check("rst_redir_v",    32'(bif.redirect_valid), 32'd0);
        check("rst_redir_pc",   bif.redirect_pc, 32'd0);
        check("rst_flush_o",    32'(flush_o), 32'd0);
        check("rst_underflow",  32'(underflow_err), 32'd0);
        check("rst_state_idle", 32'(dut.state_q == IDLE), 32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bif.pred_valid       = 0;
        bif.pred_pc          = '0;
        bif.pred_instruction = '0;
        bif.pred_target      = '0;
        bif.pred_taken       = 0;
        bif.res_valid        = 0;
        bif.res_taken        = 0;
        model_reset();
        @(negedge clk);
        do_reset();
        idle();

        // Correct taken prediction: no redirect, no flush.
        push(32'h100, 32'h140, 1);
        resolve(1);
        check("t1_modify_pc", bif.modify_pc, 32'h100);
        idle();

        // Predicted not-taken, actually taken: redirect to target, 2-cycle flush.
        push(32'h200, 32'h180, 0);
        push(32'h208, 32'h300, 1);
        resolve(1);
        check("t2_redirect_pc", bif.redirect_pc, 32'h180);
        idle();
        idle();
        idle();

        // Predicted taken, actually not taken: redirect to pc+4.
        push(32'h300, 32'h400, 1);
        resolve(0);
        check("t3_redirect_pc", bif.redirect_pc, 32'h304);
        idle();
        idle();

        // Fill the queue, then push+pop while full: push refused, count drops to 3.
        for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(i * 8), 32'h2000, 1);
        step(1, 32'h5000, 32'h0, 32'h0, 1, 1, 1);
        check("t4_count", 32'(dut.u_queue.count), 32'd3);
        // Mispredicting pop alongside a push: push discarded.
        step(1, 32'h6000, 32'h0, 32'h0, 1, 1, 0);
        idle();
        idle();

        // Drain, then resolve on empty: sticky underflow, modify_* unchanged.
        while (m_q.size() > 0) resolve(1);
        resolve(1);
        check("t5_underflow", 32'(underflow_err), 32'd1);

        // Reset in the middle of a flush.
        push(32'h700, 32'h740, 0);
        resolve(1);
        do_reset();
        idle();

`ifdef BR_RESOLVER_STATS_EN
        push(32'h10, 32'h20, 1);
        push(32'h30, 32'h40, 0);
        push(32'h50, 32'h60, 1);
        resolve(1);
        resolve(0);
        resolve(0);
        idle();
        idle();
        check("t6_resolved_cnt",   resolved_cnt,   32'd3);
        check("t6_mispredict_cnt", mispredict_cnt, 32'd1);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 500; n++) begin
            bit          pv;
            bit          rv;
            logic [31:0] pc;
            pv = ($urandom_range(0, 3) != 0);
            rv = ($urandom_range(0, 2) == 0);
            pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            step(pv, pc, {($urandom_range(0, 1) != 0) ? OPC_BNE : OPC_BEQ, 26'($urandom)},
                 $urandom, 1'($urandom), rv, 1'($urandom));
            if (n == 250) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter: DEPTH, 4, in-flight prediction queue entries (power of 2, 2..16).
REQ-002 Parameter: FLUSH_CYCLES, 2, cycles flush_o stays high after a mispredict.
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 pred_valid  input  1  fetch pushes one predicted branch.
REQ-006 pred_ready  output  1  push accepted this cycle.
REQ-007 pred_pc, pred_instruction, pred_target  input  32 each  predicted branch PC, instruction word and taken-target.
REQ-008 pred_taken  input  1  predictor's taken decision.
REQ-009 res_valid  input  1  execute stage resolves the oldest branch.
REQ-010 res_taken  input  1  actual branch outcome.
REQ-011 modify_pc, modify_instruction  output  32 each  PC and instruction of the resolved branch, fed to the predictor.
REQ-012 true_taken  output  1  actual outcome for predictor training.
REQ-013 redirect_valid  output  1  one-cycle pulse on a mispredict.
REQ-014 redirect_pc  output  32  corrected fetch PC.
REQ-015 flush_o  output  1  squash younger instructions.
REQ-016 underflow_err  output  1  sticky flag: resolution received with the queue empty.

Function
REQ-017 pred_ready SHALL be high only when the queue is not full and the state is IDLE; fullness is evaluated before any same-cycle pop.
REQ-018 A push SHALL occur when pred_valid && pred_ready and store {pc, instruction, target, taken}.
REQ-019 Resolution SHALL be in order: res_valid with a non-empty queue pops the head.
REQ-020 On a pop, modify_pc, modify_instruction and true_taken SHALL be registered from the head entry and res_taken, valid the following cycle, and held until the next pop.
REQ-021 Mispredict is defined as res_taken != head.taken.
REQ-022 On a mispredict, the next cycle SHALL raise redirect_valid for one cycle with redirect_pc = res_taken ? head.target : head.pc + 4 (mod 2^32).
REQ-023 Same cycle as REQ-022, the state SHALL move IDLE->FLUSH, the queue SHALL be cleared, and a counter SHALL load FLUSH_CYCLES.
REQ-024 In FLUSH, flush_o SHALL be 1, pushes SHALL be refused, and res_valid SHALL be ignored; when the counter reaches 0 the state SHALL return to IDLE.
REQ-025 A simultaneous push and pop in IDLE (not full) SHALL both take effect; a mispredicting pop SHALL discard the same-cycle push.
REQ-026 res_valid with an empty queue SHALL set underflow_err and SHALL leave all other outputs unchanged.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; a count of 0..DEPTH SHALL distinguish full from empty.

Reset
REQ-028 Asserting rst_n low at any time, including mid-FLUSH, SHALL empty the queue, enter IDLE, and zero every output, except pred_ready, which SHALL go to 1 after release.

Configuration
REQ-029 With BR_RESOLVER_STATS_EN defined, the block SHALL add 32-bit outputs resolved_cnt and mispredict_cnt that increment on each pop and each mispredict, saturate at all-ones, and reset to 0.
REQ-030 Without BR_RESOLVER_STATS_EN, those ports and counters SHALL NOT exist.

Structure
REQ-031 Shared package br_pkg SHALL hold the beq/bne opcode constants (6'b000100, 6'b000101), the queue entry struct, and the state enum {IDLE, FLUSH}.
REQ-032 The queue SHALL be a sub-module br_queue (synchronous FIFO with push/pop/clear/full/empty).

Verification
REQ-033 Push pc=0x100, taken=1, target=0x140; resolve taken=1 -> modify_pc=0x100, true_taken=1, no redirect, flush_o=0.
REQ-034 Push pc=0x200, taken=0, target=0x180; resolve taken=1 -> redirect_valid pulse with redirect_pc=0x180, flush_o high for 2 cycles, queue empty.
REQ-035 Push pc=0x300, taken=1; resolve taken=0 -> redirect_pc=0x304.
REQ-036 Push 4 entries -> pred_ready=0; push+pop in the same cycle when full -> push refused, count=3.
REQ-037 res_valid with the queue empty -> underflow_err=1 and modify_* unchanged; assert rst_n low mid-FLUSH -> all outputs 0, IDLE.
REQ-038 With BR_RESOLVER_STATS_EN, run 3 resolutions with 1 mispredict -> resolved_cnt=3, mispredict_cnt=1.
